alu_op_seq: RTL and testbench

Operand sequencer that sits directly upstream of the combinational `alu` (inputs `A`, `B`, `ALUOp`; output `C`). It buffers operation requests in a DEPTH-entry FIFO and issues one per cycle into registered operand lines that drive the `alu`. It then captures `C` into an output register with a valid/ready handshake. This decouples the request producer from the result consumer and gives the `alu` a registered, glitch-free input.

---
 rtl/alu_op_seq.sv | 103 ++++++++++
 tb/tb_alu_op_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_seq.sv
// alu_op_seq: FIFO-buffered operand sequencer that feeds a combinational alu and registers its result.
// Optional `ALU_SEQ_OPCHK_EN`: requests with opcode >= 6 are accepted, dropped, and flagged on err.
module alu_op_seq #(
    parameter int DEPTH = 4,
    parameter int W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    input  logic [2:0]               in_op,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    output logic [2:0]               alu_op,
    input  logic [W-1:0]             alu_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_c,
    output logic [2:0]               out_op,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [W-1:0] mem_a [DEPTH];
    logic [W-1:0] mem_b [DEPTH];
    logic [2:0]   mem_op [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic iss_v, acc, push, pop, res_adv;

    assign in_ready = count != FULL;
    assign acc = in_valid && in_ready;
`ifdef ALU_SEQ_OPCHK_EN
    assign push = acc && (in_op < 3'd6);
`else
    assign push = acc;
`endif
    assign res_adv = iss_v && (!out_valid || out_ready);
    assign pop = (count != '0) && (!iss_v || res_adv);

    // Storage needs no reset: only entries between rptr and wptr are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wptr] <= in_a;
            mem_b[wptr] <= in_b;
            mem_op[wptr] <= in_op;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr + AW'(push);
            rptr <= rptr + AW'(pop);
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_op <= '0;
            iss_v <= 1'b0;
        end else begin
            if (pop) begin
                alu_a <= mem_a[rptr];
                alu_b <= mem_b[rptr];
                alu_op <= mem_op[rptr];
            end
            iss_v <= pop || (iss_v && !res_adv);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_c <= '0;
            out_op <= '0;
            out_valid <= 1'b0;
        end else begin
            if (res_adv) begin
                out_c <= alu_c;
                out_op <= alu_op;
            end
            out_valid <= res_adv || (out_valid && !out_ready);
        end
    end

`ifdef ALU_SEQ_OPCHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err <= 1'b0;
        else err <= acc && (in_op >= 3'd6);
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_op_seq.sv
// tb_alu_op_seq: directed + randomized bench for alu_op_seq, checked against a queue of expected results.
`timescale 1ns/1ps
module tb_alu_op_seq;
    localparam int DEPTH = 4;
    localparam int W = 32;
`ifdef ALU_SEQ_OPCHK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic [2:0] in_op = '0;
    logic in_ready, out_valid, err;
    logic [W-1:0] alu_a, alu_b, alu_c, out_c;
    logic [2:0] alu_op, out_op;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;
    logic [W+2:0] expq[$];
    logic exp_err = 1'b0;

    logic [W-1:0] slit [5] = '{32'hFFFFFFFB, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [W-1:0] bpa [6] = '{32'd3, 32'd3, 32'd12, 32'd12, 32'hFFFFFFF6, 32'd1};
    logic [W-1:0] bpb [6] = '{32'd4, 32'd4, 32'd10, 32'd10, 32'd2, 32'd1};
    logic [2:0] bpo [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [W-1:0] bpr [6] = '{32'd7, 32'hFFFFFFFF, 32'd8, 32'd14, 32'h3FFFFFFD, 32'd2};

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a >> b[4:0];
            3'd5: return W'($signed(a) >>> b[4:0]);
            default: return '0;
        endcase
    endfunction

    assign alu_c = alu_f(alu_a, alu_b, alu_op);

    alu_op_seq #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_op(out_op),
        .count(count), .err(err)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every accepted legal request must come out, in order, as alu(a,b,op).
    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            exp_err = 1'b0;
        end else begin
            chk("err", err, exp_err);
            chk("in_ready", in_ready, count != DEPTH);
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious: got out_c=%h with no request outstanding, expected none", out_c);
                end else begin
                    chk("out_c", out_c, expq[0][W-1:0]);
                    chk("out_op", out_op, expq[0][W+2:W]);
                    if (out_ready) void'(expq.pop_front());
                end
            end
            exp_err = in_valid && in_ready && OPCHK && in_op >= 3'd6;
            if (in_valid && in_ready && !(OPCHK && in_op >= 3'd6))
                expq.push_back({in_op, alu_f(in_a, in_b, in_op)});
            chk("inflight_bound", expq.size() <= DEPTH + 2, 1);
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        @(posedge clk);
        #2;
        in_valid = v;
        in_a = a;
        in_b = b;
        in_op = op;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #2;
        out_ready = r;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        drive(1'b1, a, b, op);
        @(negedge clk);
        for (int n = 0; n < 30 && !in_ready; n++) @(negedge clk);
        chk("push_ready", in_ready, 1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic take(input logic [W-1:0] c, input logic [2:0] op);
        @(negedge clk);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        chk("take_valid", out_valid, 1);
        chk("take_c", out_c, c);
        chk("take_op", out_op, op);
    endtask

    task automatic drain();
        set_ready(1'b1);
        in_valid = 1'b0;
        for (int n = 0; n < 60 && (expq.size() != 0 || out_valid); n++) @(negedge clk);
        chk("drain_empty", expq.size(), 0);
        chk("drain_count", count, 0);
        chk("drain_valid", out_valid, 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_c", out_c, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        out_ready = 1'b1;

        // Reset, then sra: two-edge latency
        drive(1'b1, 32'hFFFFFFF6, 32'd2, 3'd5);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_t0", out_valid, 0);
        @(negedge clk);
        chk("lat_t1", out_valid, 0);
        @(negedge clk);
        chk("lat_t2_valid", out_valid, 1);
        chk("lat_t2_c", out_c, 32'hFFFFFFFD);
        chk("lat_t2_op", out_op, 5);

        // Streaming: one result per cycle
        fork
            begin
                for (int i = 1; i <= 5; i++) drive(1'b1, 32'hFFFFFFF6, W'(i), 3'd5);
                drive(1'b0, '0, '0, '0);
            end
            begin
                @(negedge clk);
                for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    chk("stream_valid", out_valid, 1);
                    chk("stream_c", out_c, slit[k]);
                    chk("stream_count", count <= 1, 1);
                    if (k < 4) @(negedge clk);
                end
            end
        join
        repeat (3) @(negedge clk);

        // Backpressure to full
        set_ready(1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, bpa[i], bpb[i], bpo[i]);
            @(negedge clk);
            chk("bp_ready", in_ready, 1);
        end
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        chk("bp_full", in_ready, 0);
        chk("bp_count", count, DEPTH);
        repeat (2) @(negedge clk);
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_c", out_c, 32'd7);
        set_ready(1'b1);
        take(bpr[0], bpo[0]);
        take(bpr[1], bpo[1]);
        chk("bp_restore", in_ready, 1);
        for (int i = 2; i < 6; i++) take(bpr[i], bpo[i]);
        drain();

        // FIFO wrap with alternating out_ready
        fork
            for (int i = 0; i < 10; i++) push($urandom, $urandom, 3'($urandom_range(0, 5)));
            repeat (30) begin
                @(posedge clk);
                #2;
                out_ready = ~out_ready;
            end
        join
        drain();

`ifdef ALU_SEQ_OPCHK_EN
        drive(1'b1, 32'd1, 32'd2, 3'd0);
        drive(1'b1, 32'd5, 32'd5, 3'd7);
        drive(1'b1, 32'd2, 32'd2, 3'd0);
        @(negedge clk);
        chk("opchk_err_hi", err, 1);
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        chk("opchk_err_lo", err, 0);
        take(32'd3, 3'd0);
        take(32'd4, 3'd0);
        drain();
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            in_valid = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            in_a = $urandom;
            in_b = $urandom_range(0, 1) ? W'($urandom_range(0, 40)) : $urandom;
            in_op = 3'($urandom_range(0, 7));
        end
        drain();

        // Reset with data in flight
        set_ready(1'b0);
        for (int i = 1; i <= 5; i++) drive(1'b1, W'(i), W'(i), 3'd0);
        drive(1'b0, '0, '0, '0);
        chk("fly_count", count, 3);
        reset = 1'b1;
        #1;
        chk("fly_rst_count", count, 0);
        chk("fly_rst_in_ready", in_ready, 1);
        chk("fly_rst_out_valid", out_valid, 0);
        chk("fly_rst_out_c", out_c, 0);
        chk("fly_rst_out_op", out_op, 0);
        chk("fly_rst_alu_a", alu_a, 0);
        chk("fly_rst_alu_b", alu_b, 0);
        chk("fly_rst_err", err, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        out_ready = 1'b1;
        push(32'h10, 32'h5, 3'd1);
        take(32'hB, 3'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
